// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its command-driven master:
// geometry defaults, op-codes and the master FSM state encoding.
package reg_file_pkg;

    localparam int RF_ADDR_WIDTH = 8;
    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_DEPTH      = 8;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        CLR  = 3'd4,
        RESP = 3'd5
    } state_e;

endpackage

// File: rtl/reg_file_master_if.sv
// Host-side command/response bus of the register-file master.
// The master module connects through the slave modport, the host through master.
interface reg_file_master_if
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/reg_file.sv
// DEPTH x DATA_WIDTH register file with a registered read port: RdData
// updates on the edge that samples RdEn. Out-of-range accesses are ignored.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = RF_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData
);

    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  in_range;

    assign idx      = Address[IDX_WIDTH-1:0];
    assign in_range = (Address < ADDR_LIMIT);
    assign RdData   = rd_data_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (WrEn && in_range) begin
                mem_q[idx] <= WrData;
            end
            if (RdEn && in_range) begin
                rd_data_q <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/reg_file_master.sv
// Command-driven initiator for the register file: one WRITE/READ/CLEAR per
// handshake, strobes the file, then holds a registered response until taken.
module reg_file_master
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = RF_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    reg_file_master_if.slave      bus,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData
);

    localparam int CNT_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    // Every output is computed for the state being entered, so it is valid
    // for the whole cycle spent in that state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rf_addr_d   = '0;
        rf_wdata_d  = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = bus.cmd_op;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    if (op_d == OP_CLEAR) begin
                        state_d = CLR;
                        cnt_d   = '0;
                        wr_en_d = 1'b1;
                    end else if (op_d == OP_WRITE && addr_d < ADDR_LIMIT) begin
                        state_d    = WR;
                        wr_en_d    = 1'b1;
                        rf_addr_d  = addr_d;
                        rf_wdata_d = wdata_d;
                    end else if (op_d == OP_READ && addr_d < ADDR_LIMIT) begin
                        state_d   = RD;
                        rd_en_d   = 1'b1;
                        rf_addr_d = addr_d;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = RF_RdData;
            end
            CLR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    wr_en_d   = 1'b1;
                    rf_addr_d = ADDR_WIDTH'(cnt_d);
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign RF_WrEn       = wr_en_q;
    assign RF_RdEn       = rd_en_q;
    assign RF_Address    = rf_addr_q;
    assign RF_WrData     = rf_wdata_q;

endmodule
